// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit placed after the register file.
// One operation takes WIDTH compute edges plus one writeback cycle. The
// result is presented on the register file write port (we/wr/wd). The upper
// product half or the remainder goes to hi, and divide-by-zero is flagged on dz.
module muldiv_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [AW-1:0]    wr,
  output logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [AW-1:0]        dest_q, dest_d;
  // Shared datapath: {partial product, multiplier} or {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [AW-1:0]        wr_q, wr_d;
  logic [WIDTH-1:0]     wd_q, wd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 dz_q, dz_d;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_rem;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 div_zero;

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      wd_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
    end
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, b_q};
    div_zero = (b_q == '0);
    if (op_q) begin
      // Negative trial difference means restore (keep shifted remainder).
      if (div_diff[WIDTH])
        step_acc = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: capture on start, iterate in RUN, result on WB entry.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    hi_d    = hi_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dest_d  = dest;
          count_d = '0;
          // Multiply shifts the multiplier out of the low half; divide
          // shifts the dividend out of the low half.
          acc_d   = op ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = step_acc;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = S_WB;
          wr_d    = dest_q;
          if (op_q && div_zero) begin
            wd_d = '1;
            hi_d = a_q;
            dz_d = 1'b1;
          end else begin
            wd_d = step_acc[WIDTH-1:0];
            hi_d = step_acc[2*WIDTH-1:WIDTH];
            dz_d = 1'b0;
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and write port decoded from registered state only.
  always_comb begin
    busy = (state_q != S_IDLE);
    we   = (state_q == S_WB);
    done = (state_q == S_WB);
    wr   = wr_q;
    wd   = wd_q;
    hi   = hi_q;
    dz   = dz_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected writebacks are queued when an
// operation is launched and compared when we is seen.
module tb_muldiv_unit;

  localparam int WIDTH = 8;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [AW-1:0]    dest = '0;
  logic             busy, done, we, dz;
  logic [AW-1:0]    wr;
  logic [WIDTH-1:0] wd, hi;

  typedef struct {
    logic [AW-1:0]    wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic             dz;
    int               wb_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  exp_t drop_exp;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  muldiv_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .dest(dest), .busy(busy), .done(done), .we(we), .wr(wr), .wd(wd),
    .hi(hi), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Independent reference: arithmetic operators, not the iterative algorithm.
  function automatic exp_t model(input logic o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic [AW-1:0] d);
    exp_t e;
    logic [2*WIDTH-1:0] p;
    e.wr = d;
    e.wb_cyc = 0;
    if (!o) begin
      p = 16'(x) * 16'(y);
      e.wd = p[WIDTH-1:0];
      e.hi = p[2*WIDTH-1:WIDTH];
      e.dz = 1'b0;
    end else if (y == '0) begin
      e.wd = '1;
      e.hi = x;
      e.dz = 1'b1;
    end else begin
      e.wd = x / y;
      e.hi = x % y;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Launch an operation from IDLE and queue its expected writeback.
  task automatic start_op(input logic o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [AW-1:0] d);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; dest = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(o, x, y, d);
    e.wb_cyc = cyc + WIDTH;
    exp_q.push_back(e);
    last_exp = e;
    $display("start op=%0d a=%0d b=%0d dest=%0d -> wd=0x%0h hi=0x%0h dz=%0d",
             o, x, y, d, e.wd, e.hi, e.dz);
    check_val("busy_rise", {31'b0, busy}, 32'd1);
  endtask

  // Wait (bounded) for the unit to return to IDLE.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  // Monitor: every write-enable pulse must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (we) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_we", {30'b0, wr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("wb cyc=%0d wr=%0d wd=0x%0h hi=0x%0h dz=%0d done=%0d",
                   cyc, wr, wd, hi, dz, done);
          check_val("wr", {30'b0, wr}, {30'b0, e.wr});
          check_val("wd", {24'b0, wd}, {24'b0, e.wd});
          check_val("hi", {24'b0, hi}, {24'b0, e.hi});
          check_val("dz", {31'b0, dz}, {31'b0, e.dz});
          check_val("done", {31'b0, done}, 32'd1);
          check_val("busy_wb", {31'b0, busy}, 32'd1);
          check_val("latency", cyc, e.wb_cyc);
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_we", {31'b0, we}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_wd", {24'b0, wd}, 32'd0);
    check_val("rst_hi", {24'b0, hi}, 32'd0);
    check_val("rst_dz", {31'b0, dz}, 32'd0);
    check_val("rst_wr", {30'b0, wr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations
    start_op(1'b0, 8'd13, 8'd11, 2'd2);
    wait_idle();
    check_val("hold_wd", {24'b0, wd}, {24'b0, last_exp.wd});
    check_val("hold_wr", {30'b0, wr}, {30'b0, last_exp.wr});
    start_op(1'b0, 8'd200, 8'd200, 2'd1);
    wait_idle();
    start_op(1'b1, 8'd200, 8'd7, 2'd3);
    wait_idle();
    start_op(1'b1, 8'h55, 8'd0, 2'd0);
    wait_idle();
    check_val("hold_dz", {31'b0, dz}, 32'd1);
    check_val("hold_hi", {24'b0, hi}, 32'h55);
    start_op(1'b0, 8'd2, 8'd3, 2'd1);
    wait_idle();
    check_val("dz_clear", {31'b0, dz}, 32'd0);

    // Start while busy is ignored, and mid-op input changes have no effect
    start_op(1'b0, 8'd13, 8'd11, 2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    op = 1'b1; a = 8'd1; b = 8'd1; dest = 2'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'hAA; b = 8'h33; dest = 2'd3;
    wait_idle();
    repeat (3) @(negedge clk);
    check_val("ignored_start", {31'b0, busy}, 32'd0);

    // Reset in RUN cycle 5 aborts the operation without a write
    start_op(1'b0, 8'd13, 8'd11, 2'd2);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    drop_exp = exp_q.pop_back();
    $display("reset mid-op, dropped expected wr=%0d", drop_exp.wr);
    check_val("abort_we", {31'b0, we}, 32'd0);
    check_val("abort_busy", {31'b0, busy}, 32'd0);
    check_val("abort_wd", {24'b0, wd}, 32'd0);
    check_val("abort_hi", {24'b0, hi}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 8'd3, 8'd5, 2'd1);
    wait_idle();

    // Random mix, including back-to-back launches
    for (int i = 0; i < 12; i++) begin
      logic o;
      logic [WIDTH-1:0] x, y;
      logic [AW-1:0] d;
      o = 1'($urandom_range(0, 1));
      x = 8'($urandom_range(0, 255));
      y = (i % 5 == 4) ? 8'd0 : 8'($urandom_range(0, 255));
      d = 2'($urandom_range(0, 3));
      start_op(o, x, y, d);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
